// File: rtl/reg_mask_encoder.sv
// Register-mask encoder: turns a multi-hot mask into a stream of bit indices.
// Define REG_MASK_ENC_MSB_FIRST_EN to emit highest index first.
module reg_mask_encoder #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic [IW:0]   remaining,
    output logic          zero_vec
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t         state;
    logic [N-1:0]   pending;
    logic [IW-1:0]  sel;
    logic [IW:0]    cnt;

    // Last assignment in scan order wins, so scan direction picks the order.
    always_comb begin
        sel = '0;
`ifdef REG_MASK_ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (pending[i]) sel = IW'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) sel = IW'(i);
        end
`endif
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{IW{1'b0}}, pending[i]};
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_idx   = sel;
    assign remaining = cnt;
    assign out_last  = out_valid && (cnt == (IW+1)'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pending  <= '0;
            zero_vec <= 1'b0;
        end else begin
            zero_vec <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec != '0) begin
                            pending <= in_vec;
                            state   <= EMIT;
                        end else begin
                            zero_vec <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pending <= pending & ~(N'(1) << sel);
                        if (out_last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_mask_encoder.md
Name: reg_mask_encoder

Overview:
- Inverse of the register-select decode path: accepts a 32-bit one-hot/multi-hot register mask and emits the 5-bit index of each set bit, one index per handshake.
- Emission order is lowest index first by default.
- Sits in front of the register-file port for multi-register transfers, e.g. block load/store and context save.
- Uses valid/ready on both sides and handles one mask at a time.

Parameters:
- N, 32, mask width in bits.
- IW, 5, index width; must equal clog2(N).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; 0 at a posedge resets the block.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a mask.
- in_vec  input  N  register mask to encode.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer takes out_idx this cycle.
- out_idx  output  IW  index of the current selected bit.
- out_last  output  1  current index is the final one for this mask.
- remaining  output  IW+1  count of set bits still pending, including the current one.
- zero_vec  output  1  one-cycle pulse: an all-zero mask was accepted.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, pending=0, zero_vec=0.
  - Hence out_valid=0, out_idx=0, out_last=0, remaining=0, in_ready=1 from the next cycle.
  - Reset has priority over every other event, including mid-emission; pending bits are discarded and never emitted.
- State register: IDLE, EMIT. pending is an N-bit register.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready with in_vec!=0: pending<=in_vec, go to EMIT. out_valid=1 in the following cycle (1-cycle latency).
  - On in_valid&in_ready with in_vec==0: stay in IDLE, zero_vec=1 for exactly the next cycle, no out_valid.
- EMIT:
  - in_ready=0; no input is accepted, so there is no overlap between masks.
  - out_valid=1.
  - out_idx = position of the lowest set bit of pending.
  - out_last = 1 iff pending has exactly one bit set.
  - remaining = popcount(pending).
  - On out_valid&out_ready: clear bit out_idx in pending. If out_last, go to IDLE; otherwise stay in EMIT.
- out_idx, out_last and remaining are combinational functions of registered state only. They must hold stable while out_valid&!out_ready, i.e. under arbitrary stalls.
- Throughput: one index per cycle under continuous out_ready. A mask with k set bits occupies k+1 cycles from acceptance to in_ready returning high: the accept edge plus k emit cycles. in_ready is high in the cycle after the last handshake.
- Boundaries:
  - in_vec=all ones: 32 beats; remaining starts at 32 (needs IW+1 bits).
  - A single-bit mask asserts out_last on the first beat.
  - in_valid held high during EMIT is ignored; the source must hold its data until in_ready.
  - zero_vec never coincides with out_valid.
- No X propagation: out_idx=0 whenever pending==0.

Optional Feature:
- Macro: REG_MASK_ENC_MSB_FIRST_EN.
- Defined: emission order is highest set bit first. out_idx = position of the highest set bit of pending; that bit is cleared on handshake. out_last and remaining are unchanged in meaning.
- Undefined: lowest-first order as specified above.
- The port list is identical in both builds.

Test Plan:
- Hold reset=0 for 2 cycles with in_valid=1, in_vec=32'hFFFFFFFF -> in_ready=1, out_valid=0, remaining=0, zero_vec=0; nothing is accepted while reset is low.
- in_vec=32'h00000025 accepted, out_ready=1 constant -> out_idx 0,2,5 on consecutive cycles; remaining 3,2,1; out_last only on idx 5; in_ready=1 on the next cycle.
- in_vec=32'h00008010, out_ready low for 3 cycles after out_valid rises -> out_idx=4, remaining=2 held stable for all 3 stall cycles; then idx 15 with out_last=1.
- in_vec=32'h0 accepted -> zero_vec=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- in_vec=32'h80000001, reset=0 in the cycle after idx 0 is handshaken -> next cycle out_valid=0, remaining=0, in_ready=1; idx 31 is never emitted.
- in_vec=32'hFFFFFFFF, out_ready=1 -> 32 beats, idx 0..31, remaining 32..1, out_last on idx 31. With REG_MASK_ENC_MSB_FIRST_EN defined: idx 31..0, out_last on idx 0.
